uart_hyper_cmd: RTL

Serial command front-end for the HyperRAM controller. Sits between uart_rx/uart_tx and hyper_xface. Assembles 5-byte command frames from the UART receiver and drives the controller's request/address/data inputs. Latches read data and returns a 4-byte response for every frame.

---
 rtl/uart_hyper_cmd.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_hyper_cmd.sv
// UART command front-end for the HyperRAM controller: 5-byte frames in, 4-byte response out.
// Optional build macro CMD_TIMEOUT_EN enables discarding a stalled partial frame.
module uart_hyper_cmd #(
  parameter logic [31:0] CONST_VAL      = 32'd259,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_500_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rcv,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic        hr_rd_req,
  output logic        hr_wr_req,
  output logic [31:0] hr_addr,
  output logic [31:0] hr_wr_d,
  input  logic [31:0] hr_rd_d,
  input  logic        hr_rd_rdy,
  input  logic        hr_busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {S_RX, S_EXEC, S_MEM_WAIT, S_TX_BYTE, S_TX_WAIT} state_t;

  state_t      r_state;
  logic [39:0] r_frame;
  logic [2:0]  r_bcnt;
  logic [31:0] r_resp;
  logic [31:0] r_count;
  logic [31:0] r_rd_lat;
  logic [1:0]  r_txcnt;
  logic        r_is_wr;
  logic        r_seen_low;
  logic [7:0]  w_cmd;
  logic [31:0] w_data;

  assign w_cmd  = r_frame[39:32];
  assign w_data = r_frame[31:0];

`ifdef CMD_TIMEOUT_EN
  logic [23:0] r_idle;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_RX;
      r_frame    <= '0;
      r_bcnt     <= '0;
      r_resp     <= '0;
      r_count    <= '0;
      r_rd_lat   <= '0;
      r_txcnt    <= '0;
      r_is_wr    <= 1'b0;
      r_seen_low <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      hr_rd_req  <= 1'b0;
      hr_wr_req  <= 1'b0;
      hr_addr    <= '0;
      hr_wr_d    <= '0;
      frame_err  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      r_idle     <= '0;
`endif
    end else begin
      tx_start  <= 1'b0;
      hr_rd_req <= 1'b0;
      hr_wr_req <= 1'b0;
      if (hr_rd_rdy) r_rd_lat <= hr_rd_d;
      // Bytes arriving while busy are lost; host must re-align.
      if (rcv && r_state != S_RX) frame_err <= 1'b1;

      case (r_state)
        S_RX: begin
          if (rcv) begin
            r_frame <= {r_frame[31:0], rx_data};
            if (r_bcnt == 3'd4) begin
              r_bcnt  <= '0;
              r_state <= S_EXEC;
            end else begin
              r_bcnt <= r_bcnt + 3'd1;
            end
`ifdef CMD_TIMEOUT_EN
            r_idle <= '0;
          end else if (r_bcnt != 3'd0) begin
            if (r_idle == TIMEOUT_CYCLES - 24'd1) begin
              r_bcnt <= '0;
              r_idle <= '0;
            end else begin
              r_idle <= r_idle + 24'd1;
            end
          end else begin
            r_idle <= '0;
`endif
          end
        end

        S_EXEC: begin
          r_txcnt <= '0;
          r_state <= S_TX_BYTE;
          case (w_cmd)
            8'h01: begin hr_addr <= w_data; r_resp <= w_data; end
            8'h02: begin hr_wr_d <= w_data; r_resp <= w_data; end
            8'h03: begin r_is_wr <= 1'b1; r_resp <= 32'h3; r_state <= S_MEM_WAIT; end
            8'h04: r_resp <= r_rd_lat;
            8'h05: begin r_is_wr <= 1'b0; r_resp <= 32'h5; r_state <= S_MEM_WAIT; end
            8'h06: begin r_resp <= r_count; r_count <= r_count + 32'd1; end
            8'h07: r_resp <= CONST_VAL;
            default: begin r_resp <= r_count; frame_err <= 1'b1; end
          endcase
        end

        S_MEM_WAIT: begin
          if (!hr_busy) begin
            hr_wr_req <= r_is_wr;
            hr_rd_req <= !r_is_wr;
            r_state   <= S_TX_BYTE;
          end
        end

        S_TX_BYTE: begin
          if (tx_ready) begin
            tx_start   <= 1'b1;
            tx_data    <= r_resp[31:24];
            r_seen_low <= 1'b0;
            r_state    <= S_TX_WAIT;
          end
        end

        S_TX_WAIT: begin
          // The UART may take a couple of cycles to drop ready after start.
          if (!tx_ready) begin
            r_seen_low <= 1'b1;
          end else if (r_seen_low) begin
            r_resp  <= {r_resp[23:0], 8'h00};
            r_txcnt <= r_txcnt + 2'd1;
            r_state <= (r_txcnt == 2'd3) ? S_RX : S_TX_BYTE;
          end
        end

        default: r_state <= S_RX;
      endcase
    end
  end

endmodule
